// File: rtl/tx_control_pkg.sv
// Shared types and constants for the tx_control byte sequencer.
package tx_control_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_ACK,
        WAIT_DONE,
        GAP,
        DONE
    } tx_state_t;

    localparam logic [3:0] LED_IDLE = 4'b0001;
    localparam logic [3:0] LED_SEND = 4'b0010;
    localparam logic [3:0] LED_WAIT = 4'b0100;
    localparam logic [3:0] LED_DONE = 4'b1000;

    function automatic logic [3:0] state_led(input tx_state_t s);
        case (s)
            SEND, WAIT_ACK: return LED_SEND;
            WAIT_DONE, GAP: return LED_WAIT;
            DONE:           return LED_DONE;
            default:        return LED_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/tx_down_counter.sv
// Loadable down-counter with zero flag; saturates at zero.
module tx_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/tx_control.sv
// Frame transmit sequencer: sends a captured result LSB-first through uart_tx.
// Define TX_CTRL_CHECKSUM_EN to append an XOR checksum byte to every frame.
module tx_control
    import tx_control_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int GAP_CYCLES  = 16,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              trigger,
    input  logic [DATA_W-1:0] result,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [BYTE_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    output logic              timeout_err,
    output logic [3:0]        state_leds
);

    localparam int NB = DATA_W / BYTE_W;
`ifdef TX_CTRL_CHECKSUM_EN
    localparam int FRAME_NB = NB + 1;
`else
    localparam int FRAME_NB = NB;
`endif
    localparam int BC_W    = $clog2(FRAME_NB + 1);
    localparam int CNT_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    // Both loads are "N-1" because the zero flag is tested before decrementing.
    localparam logic [CNT_W-1:0] ACK_LOAD = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    tx_state_t         state, state_nxt;
    logic [DATA_W-1:0] shift_q;
    logic [BC_W-1:0]   byte_cnt;
    logic              pending;
    logic              overrun_q;
    logic              timeout_q;
    logic              start;
    logic              last_byte;
    logic              byte_fin;
    logic              ack_to;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_zero;
    logic [CNT_W-1:0]  cnt_load_val;
`ifdef TX_CTRL_CHECKSUM_EN
    logic [BYTE_W-1:0] csum_q;
`endif

    assign start     = trigger || pending;
    assign last_byte = (byte_cnt == BC_W'(FRAME_NB - 1));
    assign byte_fin  = (state == WAIT_DONE) && !tx_busy;

    // One counter serves the ack timeout and the inter-byte gap.
    tx_down_counter #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        cnt_load     = 1'b0;
        cnt_load_val = ACK_LOAD;
        cnt_dec      = 1'b0;
        ack_to       = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = SEND;
            SEND: begin
                state_nxt = WAIT_ACK;
                cnt_load  = 1'b1;
            end
            WAIT_ACK: begin
                if (tx_busy)
                    state_nxt = WAIT_DONE;
                else if (cnt_zero) begin
                    ack_to    = 1'b1;
                    state_nxt = IDLE;
                end else
                    cnt_dec = 1'b1;
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (last_byte)
                        state_nxt = DONE;
                    else if (GAP_CYCLES == 0)
                        state_nxt = SEND;
                    else begin
                        state_nxt    = GAP;
                        cnt_load     = 1'b1;
                        cnt_load_val = GAP_LOAD;
                    end
                end
            end
            GAP: begin
                if (cnt_zero)
                    state_nxt = SEND;
                else
                    cnt_dec = 1'b1;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q   <= '0;
            byte_cnt  <= '0;
            pending   <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (ack_to)
                timeout_q <= 1'b1;
            if (state == IDLE) begin
                if (start) begin
                    shift_q  <= result;
                    byte_cnt <= '0;
                    // A fresh trigger alongside a pending one stays queued.
                    pending  <= trigger && pending;
                end
            end else if (trigger) begin
                if (pending)
                    overrun_q <= 1'b1;
                else
                    pending <= 1'b1;
            end
            if (byte_fin) begin
                byte_cnt <= byte_cnt + 1'b1;
                shift_q  <= shift_q >> BYTE_W;
`ifdef TX_CTRL_CHECKSUM_EN
                if (byte_cnt == BC_W'(NB - 1))
                    shift_q[BYTE_W-1:0] <= csum_q;
`endif
            end
        end
    end

`ifdef TX_CTRL_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            csum_q <= '0;
        else if (state == IDLE && start)
            csum_q <= '0;
        else if (state == SEND && byte_cnt < BC_W'(NB))
            csum_q <= csum_q ^ shift_q[BYTE_W-1:0];
    end
`endif

    assign tx_start    = (state == SEND);
    assign tx_data     = shift_q[BYTE_W-1:0];
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign overrun     = overrun_q;
    assign timeout_err = timeout_q;
    assign state_leds  = state_led(state);

endmodule

// File: tb/tb_tx_control.sv
// Directed bench for tx_control: default gap instance plus a zero-gap instance.
module tb_tx_control;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        uart_en = 1'b1;

    logic        trigger_a = 1'b0, trigger_b = 1'b0;
    logic [15:0] result_a = '0, result_b = '0;
    logic        busy_a, busy_b;
    logic        tx_start_a, tx_start_b;
    logic [7:0]  tx_data_a, tx_data_b;
    logic        fbusy_a, fbusy_b, done_a, done_b;
    logic        overrun_a, overrun_b, tmo_a, tmo_b;
    logic [3:0]  leds_a, leds_b;
    int          ucnt_a = 0, ucnt_b = 0;

    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          st_cyc_a[$], done_cyc_a[$], st_cyc_b[$], done_cyc_b[$];
    logic [7:0]  st_dat_a[$], st_dat_b[$];

    always #5 clk = ~clk;

    tx_control u_dut_a (
        .clk(clk), .reset_n(reset_n), .trigger(trigger_a), .result(result_a),
        .tx_busy(busy_a), .tx_start(tx_start_a), .tx_data(tx_data_a), .busy(fbusy_a),
        .done(done_a), .overrun(overrun_a), .timeout_err(tmo_a), .state_leds(leds_a)
    );

    tx_control #(.GAP_CYCLES(0)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .trigger(trigger_b), .result(result_b),
        .tx_busy(busy_b), .tx_start(tx_start_b), .tx_data(tx_data_b), .busy(fbusy_b),
        .done(done_b), .overrun(overrun_b), .timeout_err(tmo_b), .state_leds(leds_b)
    );

    // UART models: busy rises the cycle after tx_start and stays high 10 cycles.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_a <= 1'b0; ucnt_a <= 0;
        end else if (!uart_en) begin
            busy_a <= 1'b0; ucnt_a <= 0;
        end else if (tx_start_a && ucnt_a == 0) begin
            busy_a <= 1'b1; ucnt_a <= 10;
        end else if (ucnt_a != 0) begin
            ucnt_a <= ucnt_a - 1; busy_a <= (ucnt_a > 1);
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_b <= 1'b0; ucnt_b <= 0;
        end else if (tx_start_b && ucnt_b == 0) begin
            busy_b <= 1'b1; ucnt_b <= 10;
        end else if (ucnt_b != 0) begin
            ucnt_b <= ucnt_b - 1; busy_b <= (ucnt_b > 1);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_start_a) begin st_cyc_a.push_back(cyc); st_dat_a.push_back(tx_data_a); end
        if (done_a) done_cyc_a.push_back(cyc);
        if (tx_start_b) begin st_cyc_b.push_back(cyc); st_dat_b.push_back(tx_data_b); end
        if (done_b) done_cyc_b.push_back(cyc);
    end

    task automatic clear_a();
        st_cyc_a.delete(); st_dat_a.delete(); done_cyc_a.delete();
    endtask

    task automatic pulse_a(input logic [15:0] val);
        @(negedge clk); result_a = val; trigger_a = 1'b1;
        @(negedge clk); trigger_a = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_tests++;
        if ({tx_start_a, tx_data_a, fbusy_a, done_a, overrun_a, tmo_a} !== 13'h0) begin
            n_fail++; $display("FAIL reset_outputs: got %0h expected 0",
                {tx_start_a, tx_data_a, fbusy_a, done_a, overrun_a, tmo_a});
        end
        n_tests++;
        if (leds_a !== 4'b0001) begin
            n_fail++; $display("FAIL reset_leds: got %b expected 0001", leds_a);
        end
        @(negedge clk); reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] exp[$];
        int c0, k, s0, s1, sl, dc;
        clear_a();
        exp.delete(); exp.push_back(8'h34); exp.push_back(8'h12);
`ifdef TX_CTRL_CHECKSUM_EN
        exp.push_back(8'h26);
`endif
        @(negedge clk); result_a = 16'h1234; trigger_a = 1'b1; c0 = cyc;
        @(negedge clk); trigger_a = 1'b0;
        k = 0;
        while (done_cyc_a.size() == 0 && k < 1000) begin @(negedge clk); k++; end
        repeat (5) @(negedge clk);
        n_tests++;
        if (st_dat_a.size() != exp.size()) begin
            n_fail++; $display("FAIL basic_nbytes: got %0d expected %0d", st_dat_a.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            n_tests++;
            if (i >= st_dat_a.size() || st_dat_a[i] !== exp[i]) begin
                n_fail++; $display("FAIL basic_byte%0d: got %0h expected %0h", i,
                    (i < st_dat_a.size()) ? st_dat_a[i] : 8'hxx, exp[i]);
            end
        end
        s0 = (st_cyc_a.size() > 0) ? st_cyc_a[0] : -1;
        s1 = (st_cyc_a.size() > 1) ? st_cyc_a[1] : -1;
        sl = (st_cyc_a.size() > 0) ? st_cyc_a[st_cyc_a.size()-1] : -1;
        dc = (done_cyc_a.size() > 0) ? done_cyc_a[0] : -1;
        n_tests++;
        if (s0 != c0 + 1) begin
            n_fail++; $display("FAIL basic_latency: got cycle %0d expected %0d", s0, c0 + 1);
        end
        n_tests++;
        if (s1 - s0 != 28) begin
            n_fail++; $display("FAIL gap16_spacing: got %0d expected 28", s1 - s0);
        end
        n_tests++;
        if (done_cyc_a.size() != 1) begin
            n_fail++; $display("FAIL basic_done_count: got %0d expected 1", done_cyc_a.size());
        end
        n_tests++;
        if (dc != sl + 12) begin
            n_fail++; $display("FAIL basic_done_time: got %0d expected %0d", dc, sl + 12);
        end
        n_tests++;
        if (overrun_a !== 1'b0) begin
            n_fail++; $display("FAIL basic_overrun: got %b expected 0", overrun_a);
        end
    endtask

    task automatic test_gap0();
        int k, s0, s1, sl, dc;
        @(negedge clk); result_b = 16'h1234; trigger_b = 1'b1;
        @(negedge clk); trigger_b = 1'b0;
        k = 0;
        while (done_cyc_b.size() == 0 && k < 1000) begin @(negedge clk); k++; end
        repeat (3) @(negedge clk);
        s0 = (st_cyc_b.size() > 0) ? st_cyc_b[0] : -1;
        s1 = (st_cyc_b.size() > 1) ? st_cyc_b[1] : -1;
        sl = (st_cyc_b.size() > 0) ? st_cyc_b[st_cyc_b.size()-1] : -1;
        dc = (done_cyc_b.size() > 0) ? done_cyc_b[0] : -1;
        n_tests++;
        if (s1 - s0 != 12) begin
            n_fail++; $display("FAIL gap0_spacing: got %0d expected 12", s1 - s0);
        end
        n_tests++;
        if (st_dat_b.size() < 2 || st_dat_b[0] !== 8'h34 || st_dat_b[1] !== 8'h12) begin
            n_fail++; $display("FAIL gap0_bytes: got %0d bytes, first pair wrong, expected 34 12",
                st_dat_b.size());
        end
        n_tests++;
        if (dc != sl + 12) begin
            n_fail++; $display("FAIL gap0_done_time: got %0d expected %0d", dc, sl + 12);
        end
    endtask

    task automatic test_pending();
        logic [7:0] exp[$];
        int k, f2, d0;
        clear_a();
        exp.delete(); exp.push_back(8'h34); exp.push_back(8'h12);
`ifdef TX_CTRL_CHECKSUM_EN
        exp.push_back(8'h26);
`endif
        exp.push_back(8'hCD); exp.push_back(8'hAB);
`ifdef TX_CTRL_CHECKSUM_EN
        exp.push_back(8'h66);
`endif
        pulse_a(16'h1234);
        k = 0;
        while (st_cyc_a.size() == 0 && k < 100) begin @(negedge clk); k++; end
        repeat (3) @(negedge clk);
        pulse_a(16'hABCD);
        n_tests++;
        if (overrun_a !== 1'b0) begin
            n_fail++; $display("FAIL pending_no_overrun: got %b expected 0", overrun_a);
        end
        repeat (2) @(negedge clk);
        pulse_a(16'hABCD);
        n_tests++;
        if (overrun_a !== 1'b1) begin
            n_fail++; $display("FAIL pending_overrun: got %b expected 1", overrun_a);
        end
        k = 0;
        while (done_cyc_a.size() < 2 && k < 3000) begin @(negedge clk); k++; end
        repeat (40) @(negedge clk);
        n_tests++;
        if (st_dat_a.size() != exp.size()) begin
            n_fail++; $display("FAIL pending_nbytes: got %0d expected %0d", st_dat_a.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            n_tests++;
            if (i >= st_dat_a.size() || st_dat_a[i] !== exp[i]) begin
                n_fail++; $display("FAIL pending_byte%0d: got %0h expected %0h", i,
                    (i < st_dat_a.size()) ? st_dat_a[i] : 8'hxx, exp[i]);
            end
        end
        n_tests++;
        if (done_cyc_a.size() != 2) begin
            n_fail++; $display("FAIL pending_done_count: got %0d expected 2", done_cyc_a.size());
        end
        f2 = (st_cyc_a.size() > exp.size() / 2) ? st_cyc_a[exp.size() / 2] : -1;
        d0 = (done_cyc_a.size() > 0) ? done_cyc_a[0] : -1;
        n_tests++;
        if (f2 != d0 + 2) begin
            n_fail++; $display("FAIL back_to_back_idle: got %0d expected %0d", f2, d0 + 2);
        end
    endtask

    task automatic test_timeout();
        int k, s;
        clear_a();
        uart_en = 1'b0;
        pulse_a(16'h00FF);
        k = 0;
        while (st_cyc_a.size() == 0 && k < 100) begin @(negedge clk); k++; end
        s = (st_cyc_a.size() > 0) ? st_cyc_a[0] : cyc;
        k = 0;
        while (cyc < s + 255 && k < 400) begin @(negedge clk); k++; end
        n_tests++;
        if (tmo_a !== 1'b0 || fbusy_a !== 1'b1) begin
            n_fail++; $display("FAIL timeout_early: got tmo=%b busy=%b expected tmo=0 busy=1", tmo_a, fbusy_a);
        end
        @(negedge clk);
        n_tests++;
        if (tmo_a !== 1'b1) begin
            n_fail++; $display("FAIL timeout_flag: got %b expected 1", tmo_a);
        end
        n_tests++;
        if (fbusy_a !== 1'b0 || leds_a !== 4'b0001) begin
            n_fail++; $display("FAIL timeout_idle: got busy=%b leds=%b expected 0 0001", fbusy_a, leds_a);
        end
        repeat (20) @(negedge clk);
        n_tests++;
        if (done_cyc_a.size() != 0 || st_cyc_a.size() != 1) begin
            n_fail++; $display("FAIL timeout_dropped: got done=%0d starts=%0d expected 0 1",
                done_cyc_a.size(), st_cyc_a.size());
        end
        uart_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp[$];
        int k;
        clear_a();
        exp.delete(); exp.push_back(8'h78); exp.push_back(8'h56);
`ifdef TX_CTRL_CHECKSUM_EN
        exp.push_back(8'h2E);
`endif
        pulse_a(16'h1234);
        k = 0;
        while (leds_a !== 4'b0100 && k < 100) begin @(negedge clk); k++; end
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if ({tx_start_a, tx_data_a, fbusy_a, done_a, overrun_a, tmo_a} !== 13'h0) begin
            n_fail++; $display("FAIL midreset_outputs: got %0h expected 0",
                {tx_start_a, tx_data_a, fbusy_a, done_a, overrun_a, tmo_a});
        end
        n_tests++;
        if (leds_a !== 4'b0001) begin
            n_fail++; $display("FAIL midreset_leds: got %b expected 0001", leds_a);
        end
        repeat (4) @(negedge clk);
        n_tests++;
        if (st_cyc_a.size() != 1) begin
            n_fail++; $display("FAIL midreset_no_start: got %0d starts expected 1", st_cyc_a.size());
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        clear_a();
        pulse_a(16'h5678);
        k = 0;
        while (done_cyc_a.size() == 0 && k < 1000) begin @(negedge clk); k++; end
        repeat (3) @(negedge clk);
        n_tests++;
        if (st_dat_a.size() != exp.size()) begin
            n_fail++; $display("FAIL midreset_nbytes: got %0d expected %0d", st_dat_a.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            n_tests++;
            if (i >= st_dat_a.size() || st_dat_a[i] !== exp[i]) begin
                n_fail++; $display("FAIL midreset_byte%0d: got %0h expected %0h", i,
                    (i < st_dat_a.size()) ? st_dat_a[i] : 8'hxx, exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gap0();
        test_pending();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish within 50000 cycles");
        $fatal(1);
    end

endmodule

// File: doc/tx_control.md
# tx_control

Transmit sequencer downstream of the receive/command FSM. On a one-cycle `trigger` it captures the ALU result and sends it byte by byte, LSB first, through the existing UART transmitter using a start/busy handshake. It inserts a programmable idle gap between bytes and reports completion, overrun and handshake timeout. Sits between the ALU result bus and the `uart_tx` serializer.

## Interface
- `DATA_W`, 16: result width; must be a multiple of 8. Bytes per frame NB = DATA_W/8.
- `GAP_CYCLES`, 16: idle clocks between a byte's completion and the next `tx_start`; 0 means no gap.
- `ACK_TIMEOUT`, 255: maximum clocks to wait for `tx_busy` to rise after `tx_start`.
- `clk` in 1: system clock, all logic on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `trigger` in 1: one-cycle request to transmit `result`.
- `result` in DATA_W: value to send; sampled only when a frame starts.
- `tx_busy` in 1: high while the UART is serializing a byte.
- `tx_start` out 1: one-cycle pulse that launches a byte.
- `tx_data` out 8: byte being sent; held stable from `tx_start` until `tx_busy` falls.
- `busy` out 1: high while a frame is in progress, in any state other than IDLE.
- `done` out 1: one-cycle pulse after the last byte has completed.
- `overrun` out 1: sticky flag; set when a trigger is dropped.
- `timeout_err` out 1: sticky flag; set when the handshake times out.
- `state_leds` out 4: one-hot-ish state indicator for the board LEDs.

## Operation
- States: IDLE, SEND, WAIT_ACK, WAIT_DONE, GAP, DONE.
- **IDLE**
  - Start condition: `trigger` or the pending flag is set.
  - On start: load `result` into the shift register, clear the byte counter, clear the checksum accumulator, clear pending, go to SEND.
- **SEND**
  - `tx_start`=1 for exactly this cycle; `tx_data` = shift register [7:0].
  - XOR the byte into the checksum accumulator.
  - Go to WAIT_ACK.
- **WAIT_ACK**
  - If `tx_busy`=1, go to WAIT_DONE.
  - Otherwise the timeout counter increments. When it reaches ACK_TIMEOUT: set `timeout_err`, drop the rest of the frame, go to IDLE, no `done` pulse.
- **WAIT_DONE**
  - Wait for `tx_busy`=0.
  - Then increment the byte counter and shift the register right by 8.
  - If more bytes remain: go to GAP, or straight to SEND when GAP_CYCLES=0.
  - Otherwise: go to DONE.
- **GAP**: count GAP_CYCLES clocks, then go to SEND.
- **DONE**: `done`=1 for one cycle, then go to IDLE.
- Trigger outside IDLE:
  - If pending is clear, set pending.
  - If pending is already set, set `overrun`. The pending depth is one.
  - A trigger in the same cycle that DONE exits to IDLE counts as pending.
- A pending frame samples `result` in the IDLE cycle in which it starts, not at trigger time.
- `overrun` and `timeout_err` clear only on reset.
- `state_leds`: IDLE=0001, SEND/WAIT_ACK=0010, WAIT_DONE/GAP=0100, DONE=1000.

## Timing
- Reset values: all outputs 0, state IDLE, pending 0, all counters 0.
- Reset asserted mid-frame aborts immediately. No further `tx_start` is issued until after reset is released.
- Latency: `trigger` sampled at edge N, `tx_start` high in cycle N+1.
- Byte spacing:
  - With GAP_CYCLES=G>0: the next `tx_start` comes G+1 cycles after the cycle in which `tx_busy` is seen low.
  - With G=0: it comes 1 cycle after.
- `done` is high 1 cycle after the final `tx_busy` fall is sampled.
- Back-to-back frames: IDLE is visited for at least 1 cycle between frames.
- `tx_busy` already high in the SEND cycle is ignored; the ack is only checked from WAIT_ACK onward.

## Configuration
- `TX_CTRL_CHECKSUM_EN` defined:
  - After the last data byte, send one extra byte equal to the XOR of all data bytes, using the same SEND/WAIT/GAP sequence.
  - `done` follows the checksum byte. Frame length is NB+1.
- Undefined: frame length is NB. The checksum accumulator and its state path are not synthesized.

## Structure
- `tx_control_pkg` holds:
  - the state enum type `tx_state_t`;
  - `BYTE_W`=8;
  - the `state_leds` encodings.
- One sub-module, `tx_down_counter`: a loadable down-counter with a zero flag. It is shared by the GAP and WAIT_ACK timing through a select, since only one is active at a time.

## Test plan
- `result`=16'h1234, trigger, UART model with 10-cycle busy -> `tx_data` 8'h34 then 8'h12, two `tx_start` pulses, `done` once, `overrun`=0.
- Same stimulus with `TX_CTRL_CHECKSUM_EN` -> bytes 8'h34, 8'h12, 8'h26, then `done`.
- Trigger during byte 1 with `result` changed to 16'hABCD before the first frame ends -> second frame sends 8'hCD, 8'hAB. A third trigger during the first frame sets `overrun`.
- `tx_busy` held at 0 after `tx_start` -> `timeout_err`=1 after 255 cycles, state IDLE, no `done`.
- GAP_CYCLES=0 vs 16 -> measured `tx_start` spacing matches the Timing rules exactly.
- `reset_n` pulled low during WAIT_DONE -> all outputs 0 immediately. Next trigger starts a clean frame from byte 0.
